decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Pipelined RV32I decode/control stage for the 5-stage core. Decodes instr_d combinationally,
//  registers all control into the ID/EX boundary, detects load-use hazards, inserts bubbles,
//  honours EX flush and downstream hold, and counts inserted bubbles.
//  Adds jal/jalr/lui, full ALU set and optional blt/bge/bltu/bgeu support.
// PARAMETERS
//  ALU_CTRL_W        4   alu_control width; must be >=4 (codes below)
//  ENABLE_BRANCH_EXT 1   1: branch funct3 100-111 legal; 0: only beq/bne legal
//  CNT_W             16  width of bubble_cnt
// PORTS
//  clk              in  1          clock, rising edge
//  rst              in  1          asynchronous reset, active-high
//  instr_d          in  32         instruction in ID
//  valid_d          in  1          instr_d is a real instruction
//  stall_e          in  1          downstream hold: ID/EX registers keep their value
//  flush_e          in  1          EX redirect: kill instruction entering ID/EX
//  imm_src_d        out 3          comb: 000 I,001 S,010 B,011 J,100 U
//  stall_fd         out 1          comb: hold PC and IF/ID
//  valid_e          out 1          ID/EX holds an instruction (not a bubble)
//  illegal_e        out 1          ID/EX instruction is undecodable
//  reg_write_e      out 1
//  mem_write_e      out 1
//  result_src_e     out 2          00 ALU, 01 mem, 10 PC+4
//  alu_src_e        out 1          1: immediate as ALU B
//  alu_control_e    out ALU_CTRL_W 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
//  branch_e         out 1          conditional branch
//  branch_type_e    out 3          funct3 of the branch
//  jump_e           out 1          jal or jalr
//  jalr_e           out 1          target from ALU (rs1+imm)
//  rs1_e,rs2_e,rd_e out 5 each     register fields; rs1_e forced 0 for lui/jal, rs2_e 0 if unused
//  bubble_cnt       out CNT_W      load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (async): every registered output and bubble_cnt = 0 (ID/EX = bubble).
//  - Decode by opcode: 0110011 R; 0010011 I-ALU; 0000011 load (ADD, result 01);
//    0100011 store (ADD, mem_write); 1100011 branch (SUB, alu_src 0); 1101111 jal (result 10);
//    1100111 jalr (ADD, alu_src 1, result 10, jalr); 0110111 lui (rs1=0, ADD, imm U).
//  - ALU funct3: 000 ADD (SUB only if R-type and funct7[5]); 001 SLL; 010 SLT; 011 SLTU;
//    100 XOR; 101 SRL, SRA if funct7[5] (R and I); 110 OR; 111 AND.
//  - Illegal: unknown opcode; branch funct3 010/011; branch funct3 1xx when ENABLE_BRANCH_EXT=0.
//    Captured as valid_e=1, illegal_e=1 with reg_write/mem_write/branch/jump all 0.
//  - Uses rs1: all except jal, lui. Uses rs2: R, store, branch.
//  - load_use = valid_e & result_src_e==01 & rd_e!=0 & valid_d &
//    ((uses_rs1 & rs1==rd_e) | (uses_rs2 & rs2==rd_e)).  stall_fd = load_use | stall_e.
//  - ID/EX update per edge, priority: stall_e hold > flush_e bubble > load_use bubble >
//    capture decode (valid_e=valid_d; valid_d=0 captures a bubble).
//  - flush_e is ignored while stall_e=1; its source holds it until stall_e drops.
//  - Bubble = all registered outputs 0. Latency: instr_d to *_e outputs = 1 cycle.
//  - bubble_cnt +1 on each edge where a load_use bubble is inserted (not on flush, not
//    while stall_e); saturates at all-ones, never wraps.
//  - Reset mid-stall: ID/EX and bubble_cnt clear immediately; stall_fd then follows inputs.
// TESTING
//  - add x3,x1,x2 then sub x4,x3,x1 -> cycle 1: alu_control_e=0, reg_write_e=1, rd_e=3; cycle 2: alu_control_e=1.
//  - lw x5,0(x1) then add x6,x5,x2 -> stall_fd=1 one cycle, bubble (valid_e=0), bubble_cnt=1, add captured next.
//  - lw x0,0(x1) then add x6,x0,x2 -> no stall, bubble_cnt stays 0.
//  - blt with ENABLE_BRANCH_EXT=0 -> illegal_e=1, branch_e=0; =1 -> branch_e=1, branch_type_e=100.
//  - flush_e=1 with jal valid -> valid_e=0; same with stall_e=1 -> ID/EX unchanged.
//  - CNT_W=2, 5 load-use pairs -> bubble_cnt 1,2,3,3,3; rst pulse mid-run -> all outputs 0 async.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// RV32I decode/control stage: combinational decode of instr_d into the ID/EX register,
// with load-use bubble insertion, EX flush/hold handling and a saturating bubble counter.
module decode_ctrl_pipe #(
  parameter int ALU_CTRL_W        = 4,
  parameter bit ENABLE_BRANCH_EXT = 1'b1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  valid_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic [2:0]            imm_src_d,
  output logic                  stall_fd,
  output logic                  valid_e,
  output logic                  illegal_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic [1:0]            result_src_e,
  output logic                  alu_src_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  branch_e,
  output logic [2:0]            branch_type_e,
  output logic                  jump_e,
  output logic                  jalr_e,
  output logic [4:0]            rs1_e,
  output logic [4:0]            rs2_e,
  output logic [4:0]            rd_e,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  branch;
    logic [2:0]            branch_type;
    logic                  jump;
    logic                  jalr;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       unused_bits;

  assign opcode      = instr_d[6:0];
  assign rd_d        = instr_d[11:7];
  assign funct3      = instr_d[14:12];
  assign rs1_d       = instr_d[19:15];
  assign rs2_d       = instr_d[24:20];
  assign funct7_b5   = instr_d[30];
  assign unused_bits = ^{instr_d[31], instr_d[29:25]};

  // alt selects SUB (only when allow_sub, i.e. R-type) or SRA.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    case (f3)
      3'b000:  alu_sel = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic       d_illegal, d_reg_write, d_mem_write, d_alu_src;
  logic       d_branch, d_jump, d_jalr, d_uses_rs1, d_uses_rs2;
  logic [1:0] d_result_src;
  logic [3:0] d_alu;
  logic       branch_legal;

  assign branch_legal = (funct3[2:1] == 2'b00) || (ENABLE_BRANCH_EXT && funct3[2]);

  always_comb begin
    d_illegal    = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_write  = 1'b0;
    d_result_src = 2'b00;
    d_alu_src    = 1'b0;
    d_alu        = ALU_ADD;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_jalr       = 1'b0;
    d_uses_rs1   = 1'b1;
    d_uses_rs2   = 1'b0;
    imm_src_d    = 3'b000;
    case (opcode)
      OP_R: begin
        d_reg_write = 1'b1;
        d_alu       = alu_sel(funct3, funct7_b5, 1'b1);
        d_uses_rs2  = 1'b1;
      end
      OP_I: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_alu       = alu_sel(funct3, funct7_b5, 1'b0);
      end
      OP_LOAD: begin
        d_reg_write  = 1'b1;
        d_alu_src    = 1'b1;
        d_result_src = 2'b01;
      end
      OP_STORE: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        d_uses_rs2  = 1'b1;
        imm_src_d   = 3'b001;
      end
      OP_BRANCH: begin
        d_alu      = ALU_SUB;
        d_uses_rs2 = 1'b1;
        imm_src_d  = 3'b010;
        d_branch   = branch_legal;
        d_illegal  = !branch_legal;
      end
      OP_JAL: begin
        d_reg_write  = 1'b1;
        d_result_src = 2'b10;
        d_jump       = 1'b1;
        d_uses_rs1   = 1'b0;
        imm_src_d    = 3'b011;
      end
      OP_JALR: begin
        d_reg_write  = 1'b1;
        d_alu_src    = 1'b1;
        d_result_src = 2'b10;
        d_jump       = 1'b1;
        d_jalr       = 1'b1;
      end
      OP_LUI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_uses_rs1  = 1'b0;
        imm_src_d   = 3'b100;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Illegal instructions carry only valid+illegal; rd is zeroed when nothing is written.
  idex_t idex_next, idex_q;

  always_comb begin
    idex_next = '0;
    if (valid_d) begin
      idex_next.valid = 1'b1;
      if (d_illegal) begin
        idex_next.illegal = 1'b1;
      end else begin
        idex_next.reg_write   = d_reg_write;
        idex_next.mem_write   = d_mem_write;
        idex_next.result_src  = d_result_src;
        idex_next.alu_src     = d_alu_src;
        idex_next.alu_control = ALU_CTRL_W'(d_alu);
        idex_next.branch      = d_branch;
        idex_next.branch_type = d_branch ? funct3 : 3'b000;
        idex_next.jump        = d_jump;
        idex_next.jalr        = d_jalr;
        idex_next.rs1         = d_uses_rs1 ? rs1_d : 5'd0;
        idex_next.rs2         = d_uses_rs2 ? rs2_d : 5'd0;
        idex_next.rd          = d_reg_write ? rd_d : 5'd0;
      end
    end
  end

  logic load_use;

  assign load_use = idex_q.valid && (idex_q.result_src == 2'b01) && (idex_q.rd != 5'd0) &&
                    valid_d && ((d_uses_rs1 && (rs1_d == idex_q.rd)) ||
                                (d_uses_rs2 && (rs2_d == idex_q.rd)));
  assign stall_fd = load_use || stall_e;

  logic [CNT_W-1:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q       <= '0;
      bubble_cnt_q <= '0;
    end else if (!stall_e) begin
      if (flush_e) begin
        idex_q <= '0;
      end else if (load_use) begin
        idex_q <= '0;
        if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end else begin
        idex_q <= idex_next;
      end
    end
  end

  assign valid_e       = idex_q.valid;
  assign illegal_e     = idex_q.illegal;
  assign reg_write_e   = idex_q.reg_write;
  assign mem_write_e   = idex_q.mem_write;
  assign result_src_e  = idex_q.result_src;
  assign alu_src_e     = idex_q.alu_src;
  assign alu_control_e = idex_q.alu_control;
  assign branch_e      = idex_q.branch;
  assign branch_type_e = idex_q.branch_type;
  assign jump_e        = idex_q.jump;
  assign jalr_e        = idex_q.jalr;
  assign rs1_e         = idex_q.rs1;
  assign rs2_e         = idex_q.rs2;
  assign rd_e          = idex_q.rd;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: two instances (branch ext on / 16-bit counter, branch ext off /
// 2-bit counter) share inputs and are compared against a behavioural ID/EX model.
module tb_decode_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [3:0] alu_control;
    logic       branch;
    logic [2:0] branch_type;
    logic       jump;
    logic       jalr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;

  logic [2:0]  imm_src_d_a, imm_src_d_b, branch_type_e_a, branch_type_e_b;
  logic        stall_fd_a, valid_e_a, illegal_e_a, reg_write_e_a, mem_write_e_a, alu_src_e_a;
  logic        branch_e_a, jump_e_a, jalr_e_a;
  logic        stall_fd_b, valid_e_b, illegal_e_b, reg_write_e_b, mem_write_e_b, alu_src_e_b;
  logic        branch_e_b, jump_e_b, jalr_e_b;
  logic [1:0]  result_src_e_a, result_src_e_b;
  logic [3:0]  alu_control_e_a, alu_control_e_b;
  logic [4:0]  rs1_e_a, rs2_e_a, rd_e_a, rs1_e_b, rs2_e_b, rd_e_b;
  logic [15:0] bubble_cnt_a;
  logic [1:0]  bubble_cnt_b;

  decode_ctrl_pipe #(.ALU_CTRL_W(4), .ENABLE_BRANCH_EXT(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .imm_src_d(imm_src_d_a), .stall_fd(stall_fd_a), .valid_e(valid_e_a),
    .illegal_e(illegal_e_a), .reg_write_e(reg_write_e_a), .mem_write_e(mem_write_e_a),
    .result_src_e(result_src_e_a), .alu_src_e(alu_src_e_a), .alu_control_e(alu_control_e_a),
    .branch_e(branch_e_a), .branch_type_e(branch_type_e_a), .jump_e(jump_e_a),
    .jalr_e(jalr_e_a), .rs1_e(rs1_e_a), .rs2_e(rs2_e_a), .rd_e(rd_e_a),
    .bubble_cnt(bubble_cnt_a));

  decode_ctrl_pipe #(.ALU_CTRL_W(4), .ENABLE_BRANCH_EXT(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .imm_src_d(imm_src_d_b), .stall_fd(stall_fd_b), .valid_e(valid_e_b),
    .illegal_e(illegal_e_b), .reg_write_e(reg_write_e_b), .mem_write_e(mem_write_e_b),
    .result_src_e(result_src_e_b), .alu_src_e(alu_src_e_b), .alu_control_e(alu_control_e_b),
    .branch_e(branch_e_b), .branch_type_e(branch_type_e_b), .jump_e(jump_e_b),
    .jalr_e(jalr_e_b), .rs1_e(rs1_e_b), .rs2_e(rs2_e_b), .rd_e(rd_e_b),
    .bubble_cnt(bubble_cnt_b));

  ctrl_t obs_a, obs_b;
  assign obs_a = {valid_e_a, illegal_e_a, reg_write_e_a, mem_write_e_a, result_src_e_a,
                  alu_src_e_a, alu_control_e_a, branch_e_a, branch_type_e_a, jump_e_a,
                  jalr_e_a, rs1_e_a, rs2_e_a, rd_e_a};
  assign obs_b = {valid_e_b, illegal_e_b, reg_write_e_b, mem_write_e_b, result_src_e_b,
                  alu_src_e_b, alu_control_e_b, branch_e_b, branch_type_e_b, jump_e_b,
                  jalr_e_b, rs1_e_b, rs2_e_b, rd_e_b};

  // reference model state and scoreboard
  int          total = 0, bad = 0;
  ctrl_t       exp_a = '0, exp_b = '0;
  int          cnt_a = 0, cnt_b = 0;
  logic        exp_stall_fd, obs_stall_a, obs_stall_b;
  logic [2:0]  exp_imm, obs_imm_a, obs_imm_b;
  logic [1:0]  exp_q[$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  // Decode by instruction class; ALU code from a funct3 lookup plus one for the alternate form.
  function automatic ctrl_t ref_decode(input logic [31:0] ins, input bit ext,
                                       output logic [2:0] imm, output bit u1, output bit u2);
    int          alu_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    logic [6:0]  op = ins[6:0];
    int          f3 = int'(ins[14:12]);
    bit          alt = ins[30];
    bit          legal = 1'b1;
    ctrl_t       r = '0;
    imm = 3'd0;
    u1 = !(op == 7'b1101111 || op == 7'b0110111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    case (op)
      7'b0110011: begin
        r.reg_write = 1; r.alu_control = 4'(alu_tab[f3] + int'(alt && (f3 == 0 || f3 == 5)));
      end
      7'b0010011: begin
        r.reg_write = 1; r.alu_src = 1; r.alu_control = 4'(alu_tab[f3] + int'(alt && f3 == 5));
      end
      7'b0000011: begin r.reg_write = 1; r.alu_src = 1; r.result_src = 2'b01; end
      7'b0100011: begin r.mem_write = 1; r.alu_src = 1; imm = 3'd1; end
      7'b1100011: begin
        imm = 3'd2;
        legal = (f3 == 0 || f3 == 1 || (ext && f3 >= 4));
        r.branch = 1; r.branch_type = 3'(f3); r.alu_control = 4'd1;
      end
      7'b1101111: begin r.reg_write = 1; r.result_src = 2'b10; r.jump = 1; imm = 3'd3; end
      7'b1100111: begin
        r.reg_write = 1; r.alu_src = 1; r.result_src = 2'b10; r.jump = 1; r.jalr = 1;
      end
      7'b0110111: begin r.reg_write = 1; r.alu_src = 1; imm = 3'd4; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      r = '0;
      r.illegal = 1;
    end else begin
      r.rs1 = u1 ? ins[19:15] : 5'd0;
      r.rs2 = u2 ? ins[24:20] : 5'd0;
      r.rd  = r.reg_write ? ins[11:7] : 5'd0;
    end
    r.valid = 1;
    return r;
  endfunction

  task automatic reset_model();
    exp_a = '0; exp_b = '0; cnt_a = 0; cnt_b = 0;
  endtask

  // driver: one clock of stimulus, model update at the edge, samples comb outputs before it
  task automatic cycle(input logic [31:0] ins, input logic vd, input logic se, input logic fe);
    ctrl_t nxt_a, nxt_b;
    logic [2:0] imm;
    bit u1, u2, lu;
    @(negedge clk);
    instr_d = ins; valid_d = vd; stall_e = se; flush_e = fe;
    nxt_a = ref_decode(ins, 1'b1, imm, u1, u2);
    nxt_b = ref_decode(ins, 1'b0, imm, u1, u2);
    lu = exp_a.valid && exp_a.result_src == 2'b01 && exp_a.rd != 0 && vd &&
         ((u1 && ins[19:15] == exp_a.rd) || (u2 && ins[24:20] == exp_a.rd));
    exp_stall_fd = lu || se;
    exp_imm = imm;
    #2;
    obs_stall_a = stall_fd_a; obs_stall_b = stall_fd_b;
    obs_imm_a = imm_src_d_a; obs_imm_b = imm_src_d_b;
    @(posedge clk);
    if (!se) begin
      if (fe || lu || !vd) begin
        exp_a = '0; exp_b = '0;
        if (!fe && lu) begin
          cnt_a = (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
          cnt_b = (cnt_b < 3) ? cnt_b + 1 : cnt_b;
        end
      end else begin
        exp_a = nxt_a; exp_b = nxt_b;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (obs_a !== ctrl_t'(0)) begin bad++; $display("FAIL reset_a got=%h want=0", obs_a); end
    total++; if (obs_b !== ctrl_t'(0)) begin bad++; $display("FAIL reset_b got=%h want=0", obs_b); end
    total++; if (bubble_cnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d want=0", bubble_cnt_a); end
    total++; if (stall_fd_a !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_fd_a); end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_add_sub();
    cycle(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 0);
    total++; if (alu_control_e_a !== 4'd0 || reg_write_e_a !== 1'b1 || rd_e_a !== 5'd3) begin
      bad++; $display("FAIL add alu=%0d rw=%b rd=%0d want alu=0 rw=1 rd=3", alu_control_e_a, reg_write_e_a, rd_e_a);
    end
    total++; if (obs_a !== exp_a) begin bad++; $display("FAIL add_full got=%h want=%h", obs_a, exp_a); end
    cycle(enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4), 1, 0, 0);
    total++; if (alu_control_e_a !== 4'd1) begin bad++; $display("FAIL sub alu got=%0d want=1", alu_control_e_a); end
    total++; if (obs_stall_a !== 1'b0) begin bad++; $display("FAIL sub_stall got=%b want=0", obs_stall_a); end
  endtask

  task automatic test_load_use();
    cycle(enc_lw(5'd5, 5'd1), 1, 0, 0);
    cycle(enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6), 1, 0, 0);
    total++; if (obs_stall_a !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", obs_stall_a); end
    total++; if (valid_e_a !== 1'b0) begin bad++; $display("FAIL lu_bubble valid_e got=%b want=0", valid_e_a); end
    total++; if (bubble_cnt_a !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", bubble_cnt_a); end
    cycle(enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6), 1, 0, 0);
    total++; if (obs_stall_a !== 1'b0 || valid_e_a !== 1'b1 || rd_e_a !== 5'd6) begin
      bad++; $display("FAIL lu_capture stall=%b valid=%b rd=%0d want 0 1 6", obs_stall_a, valid_e_a, rd_e_a);
    end
  endtask

  task automatic test_load_x0();
    cycle(enc_lw(5'd0, 5'd1), 1, 0, 0);
    cycle(enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd6), 1, 0, 0);
    total++; if (obs_stall_a !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b want=0", obs_stall_a); end
    total++; if (bubble_cnt_a !== 16'd1 || valid_e_a !== 1'b1) begin
      bad++; $display("FAIL x0_cnt cnt=%0d valid=%b want 1 1", bubble_cnt_a, valid_e_a);
    end
  endtask

  task automatic test_branch_ext();
    logic [31:0] blt;
    blt = {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
    cycle(blt, 1, 0, 0);
    total++; if (illegal_e_b !== 1'b1 || branch_e_b !== 1'b0) begin
      bad++; $display("FAIL blt_noext illegal=%b branch=%b want 1 0", illegal_e_b, branch_e_b);
    end
    total++; if (branch_e_a !== 1'b1 || branch_type_e_a !== 3'b100 || illegal_e_a !== 1'b0) begin
      bad++; $display("FAIL blt_ext branch=%b type=%b illegal=%b want 1 100 0", branch_e_a, branch_type_e_a, illegal_e_a);
    end
    total++; if (obs_imm_a !== 3'b010) begin bad++; $display("FAIL blt_imm got=%b want=010", obs_imm_a); end
  endtask

  task automatic test_flush();
    logic [31:0] jal;
    jal = {20'h00100, 5'd1, 7'b1101111};
    cycle(jal, 1, 0, 1);
    total++; if (valid_e_a !== 1'b0) begin bad++; $display("FAIL flush_jal valid got=%b want=0", valid_e_a); end
    cycle(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd9), 1, 0, 0);
    cycle(jal, 1, 1, 1);
    total++; if (valid_e_a !== 1'b1 || rd_e_a !== 5'd9 || alu_control_e_a !== 4'd3 || jump_e_a !== 1'b0) begin
      bad++; $display("FAIL flush_stall valid=%b rd=%0d alu=%0d jump=%b want 1 9 3 0", valid_e_a, rd_e_a, alu_control_e_a, jump_e_a);
    end
    total++; if (obs_stall_a !== 1'b1) begin bad++; $display("FAIL flush_stall_fd got=%b want=1", obs_stall_a); end
    cycle(jal, 1, 0, 0);
    total++; if (jump_e_a !== 1'b1 || rs1_e_a !== 5'd0 || result_src_e_a !== 2'b10) begin
      bad++; $display("FAIL jal jump=%b rs1=%0d res=%b want 1 0 10", jump_e_a, rs1_e_a, result_src_e_a);
    end
  endtask

  task automatic test_reset_mid_stall();
    cycle(enc_lw(5'd7, 5'd2), 1, 0, 0);
    @(negedge clk);
    instr_d = enc_r(7'h00, 5'd1, 5'd7, 3'b000, 5'd8); valid_d = 1'b1; stall_e = 1'b1; flush_e = 1'b0;
    #2;
    total++; if (stall_fd_a !== 1'b1) begin bad++; $display("FAIL pre_rst_stall got=%b want=1", stall_fd_a); end
    rst = 1'b1;
    #1;
    total++; if (obs_a !== ctrl_t'(0) || obs_b !== ctrl_t'(0)) begin
      bad++; $display("FAIL async_rst a=%h b=%h want 0", obs_a, obs_b);
    end
    total++; if (bubble_cnt_a !== 16'd0 || bubble_cnt_b !== 2'd0) begin
      bad++; $display("FAIL async_rst_cnt a=%0d b=%0d want 0", bubble_cnt_a, bubble_cnt_b);
    end
    total++; if (stall_fd_a !== 1'b1) begin bad++; $display("FAIL rst_stall_fd got=%b want=1", stall_fd_a); end
    stall_e = 1'b0;
    #1;
    total++; if (stall_fd_a !== 1'b0) begin bad++; $display("FAIL rst_stall_rel got=%b want=0", stall_fd_a); end
    reset_model();
    @(negedge clk);
    rst = 1'b0; valid_d = 1'b0;
  endtask

  task automatic test_saturate();
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      logic [1:0] want;
      cycle(enc_lw(5'd5, 5'd1), 1, 0, 0);
      cycle(enc_r(7'h00, 5'd5, 5'd3, 3'b000, 5'd6), 1, 0, 0);
      want = exp_q.pop_front();
      total++; if (bubble_cnt_b !== want) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, bubble_cnt_b, want); end
      cycle(enc_r(7'h00, 5'd5, 5'd3, 3'b000, 5'd6), 1, 0, 0);
    end
    total++; if (bubble_cnt_a !== 16'd5) begin bad++; $display("FAIL sat_cnt_wide got=%0d want=5", bubble_cnt_a); end
  endtask

  task automatic test_random();
    logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) ins[6:0] = 7'b0000011;
      cycle(ins, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 7) == 0));
      total++; if (obs_stall_a !== exp_stall_fd || obs_stall_b !== exp_stall_fd) begin
        bad++; $display("FAIL rnd_stall[%0d] a=%b b=%b want=%b", n, obs_stall_a, obs_stall_b, exp_stall_fd);
      end
      total++; if (obs_imm_a !== exp_imm || obs_imm_b !== exp_imm) begin
        bad++; $display("FAIL rnd_imm[%0d] a=%b b=%b want=%b", n, obs_imm_a, obs_imm_b, exp_imm);
      end
      total++; if (obs_a !== exp_a) begin bad++; $display("FAIL rnd_idex_a[%0d] got=%h want=%h", n, obs_a, exp_a); end
      total++; if (obs_b !== exp_b) begin bad++; $display("FAIL rnd_idex_b[%0d] got=%h want=%h", n, obs_b, exp_b); end
      total++; if (bubble_cnt_a !== 16'(cnt_a) || bubble_cnt_b !== 2'(cnt_b)) begin
        bad++; $display("FAIL rnd_cnt[%0d] a=%0d b=%0d want %0d %0d", n, bubble_cnt_a, bubble_cnt_b, cnt_a, cnt_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_load_use();
    test_load_x0();
    test_branch_ext();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
